// File: rtl/rom_msg_pkg.sv
// Shared state encoding and character constants for the ROM message streamer.
// Build option ROM_MSG_CRLF_EN adds the CR/LF trailer states.
package rom_msg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StSend,
`ifdef ROM_MSG_CRLF_EN
    StCr,
    StLf,
`endif
    StFinish
  } state_e;

  localparam logic [7:0] MSG_TERM = 8'h00;
  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;

endpackage

// File: rtl/rom_msg_streamer_if.sv
// ROM read port plus UART TX valid/ready byte stream.
// The streamer is the master; the ROM/UART side is the slave.
interface rom_msg_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0]      rom_q;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output rom_addr, tx_data, tx_valid, input rom_q, tx_ready);
  modport slave  (input rom_addr, tx_data, tx_valid, output rom_q, tx_ready);
endinterface

// File: rtl/tx_hold_reg.sv
// Output byte register for the UART TX handshake: holds data and valid until accepted.
// A load in the same cycle as an accept takes priority so trailer bytes can follow back to back.
module tx_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             fire
);

  assign fire = valid & ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_msg_streamer.sv
// Walks the message ROM from start_addr and streams bytes to the UART TX until a 0x00 or the
// top address. Define ROM_MSG_CRLF_EN to append CR LF to every message.
module rom_msg_streamer
  import rom_msg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  rom_msg_streamer_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_cnt
);

  localparam logic [1:0]            LatLast = 2'(ROM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrTop = '1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH + 1)'(1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            lat_cnt;
  logic                  is_term;
  logic                  hold_clr;
  logic                  hold_load;
  logic [WIDTH-1:0]      hold_byte;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_valid;
  logic                  tx_fire;

  assign is_term      = (bus.rom_q == WIDTH'(MSG_TERM));
  assign bus.rom_addr = addr;
  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = tx_valid;

  always_comb begin
    hold_clr  = abort && (state != StIdle);
    hold_load = 1'b0;
    hold_byte = bus.rom_q;
    case (state)
      StCheck: begin
        hold_load = !is_term;
`ifdef ROM_MSG_CRLF_EN
        if (is_term) begin
          hold_load = 1'b1;
          hold_byte = WIDTH'(CHR_CR);
        end
`endif
      end
`ifdef ROM_MSG_CRLF_EN
      StSend: begin
        if (tx_fire && addr == AddrTop) begin
          hold_load = 1'b1;
          hold_byte = WIDTH'(CHR_CR);
        end
      end
      StCr: begin
        if (tx_fire) begin
          hold_load = 1'b1;
          hold_byte = WIDTH'(CHR_LF);
        end
      end
`endif
      default: ;
    endcase
  end

  tx_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (hold_clr),
    .load      (hold_load),
    .load_data (hold_byte),
    .ready     (bus.tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .fire      (tx_fire)
  );

  // done and busy change together on entry to StFinish, so done lands in the cycle after CHECK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      addr     <= '0;
      lat_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= StIdle;
        busy  <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (start) begin
              addr     <= start_addr;
              byte_cnt <= '0;
              busy     <= 1'b1;
              lat_cnt  <= '0;
              state    <= StFetch;
            end
          end
          StFetch: begin
            if (lat_cnt == LatLast) state <= StCheck;
            else lat_cnt <= lat_cnt + 2'd1;
          end
          StCheck: begin
            if (is_term) begin
`ifdef ROM_MSG_CRLF_EN
              state <= StCr;
`else
              state <= StFinish;
              done  <= 1'b1;
              busy  <= 1'b0;
`endif
            end else begin
              state <= StSend;
            end
          end
          StSend: begin
            if (tx_fire) begin
              byte_cnt <= byte_cnt + CntOne;
              if (addr == AddrTop) begin
`ifdef ROM_MSG_CRLF_EN
                state <= StCr;
`else
                state <= StFinish;
                done  <= 1'b1;
                busy  <= 1'b0;
`endif
              end else begin
                addr    <= addr + AddrOne;
                lat_cnt <= '0;
                state   <= StFetch;
              end
            end
          end
`ifdef ROM_MSG_CRLF_EN
          StCr: begin
            if (tx_fire) begin
              byte_cnt <= byte_cnt + CntOne;
              state    <= StLf;
            end
          end
          StLf: begin
            if (tx_fire) begin
              byte_cnt <= byte_cnt + CntOne;
              state    <= StFinish;
              done     <= 1'b1;
              busy     <= 1'b0;
            end
          end
`endif
          StFinish: state <= StIdle;
          default:  state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/rom_msg_streamer.md
Name: rom_msg_streamer

Overview:
- Downstream consumer of the message ROM: walks ROM addresses from a start address and hands each byte to the UART transmitter over a valid/ready handshake.
- Stops at the first 0x00 terminator byte or at the top of the address space.
- Sits between the message ROM and the UART TX stage. Top-level control pulses start; the block reports busy and done.

Parameters:
- ADDR_WIDTH, 5, ROM address width; message space is 2**ADDR_WIDTH bytes.
- WIDTH, 8, data byte width; must match the UART TX data width.
- ROM_LATENCY, 1, cycles from a rom_addr change to valid rom_q; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to send a message; ignored while busy.
- start_addr  in  ADDR_WIDTH  first ROM address of the message; sampled on an accepted start.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- rom_addr  out  ADDR_WIDTH  registered address driven to the ROM.
- rom_q  in  WIDTH  ROM read data, valid ROM_LATENCY cycles after a rom_addr change.
- tx_data  out  WIDTH  byte offered to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte this cycle.
- busy  out  1  high from an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse when a message completes normally.
- byte_cnt  out  ADDR_WIDTH+1  bytes accepted by TX in the current or last message.

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; rom_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, byte_cnt=0. Reset overrides every other input.
- IDLE:
  - On start=1: rom_addr<=start_addr, byte_cnt<=0, busy<=1, then go to FETCH.
- FETCH:
  - Wait counter runs ROM_LATENCY cycles, then go to CHECK.
  - Total start-to-first-tx_valid latency is ROM_LATENCY+2 cycles.
- CHECK:
  - If rom_q==0: go to FINISH.
  - Otherwise: tx_data<=rom_q, tx_valid<=1, go to SEND.
- SEND:
  - Hold tx_data and tx_valid stable until tx_ready=1. tx_valid never drops without a handshake, except on abort or reset.
  - On the handshake: tx_valid<=0 and byte_cnt<=byte_cnt+1.
    - If rom_addr == 2**ADDR_WIDTH-1: go to FINISH. No wrap-around; the last byte is sent and the message ends unterminated.
    - Else: rom_addr<=rom_addr+1 and go to FETCH.
- FINISH: done<=1 for exactly one cycle, busy<=0, go to IDLE.
- tx_ready while tx_valid=0 is ignored. tx_ready may be held high permanently; the block then sends one byte every ROM_LATENCY+2 cycles.
- start while busy=1 is ignored and not queued. start and abort in the same cycle in IDLE: abort wins and start is dropped.
- abort in any non-IDLE state:
  - Next cycle: tx_valid=0, busy=0, state=IDLE, no done pulse.
  - byte_cnt keeps the count reached so far.
- start_addr with a terminator at that address: no tx_valid at all; done pulses ROM_LATENCY+2 cycles after start; byte_cnt=0.
- byte_cnt is ADDR_WIDTH+1 bits wide so a full 2**ADDR_WIDTH-byte message cannot overflow it.

Optional Feature:
- Macro: ROM_MSG_CRLF_EN.
- Defined:
  - On a terminator or at the top address, go through states CR then LF before FINISH.
  - CR and LF send 0x0D then 0x0A with the same SEND handshake rules.
  - byte_cnt counts both bytes. done pulses after the LF handshake.
  - abort during CR or LF behaves as in any other state.
- Not defined: the CR and LF states do not exist and the termination path goes straight to FINISH.

Decomposition:
- Shared package rom_msg_pkg:
  - state enum: IDLE, FETCH, CHECK, SEND, CR, LF, FINISH.
  - constants: MSG_TERM=8'h00, CHR_CR=8'h0D, CHR_LF=8'h0A.
- One natural sub-module: tx_hold_reg, which holds the byte and generates tx_valid under the valid/ready handshake.
- FSM, address counter and latency counter stay in the top module.

Test Plan:
- ROM 48 65 6C 6C 6F 00 at 0..5, start_addr=0, tx_ready tied 1 -> tx_data 0x48,0x65,0x6C,0x6C,0x6F in order; done pulses once; byte_cnt=5; busy low after done.
- Same message, tx_ready toggled randomly -> tx_data stable while tx_valid=1 and tx_ready=0; no byte lost or duplicated; byte_cnt=5.
- ROM[7]=00, start_addr=7 -> no tx_valid; done exactly ROM_LATENCY+2 cycles after start; byte_cnt=0.
- ROM[28..31]=41 42 43 44 with no terminator, start_addr=28 -> 4 bytes sent; rom_addr stops at 31 and never wraps to 0; done pulses; byte_cnt=4.
- abort during the second SEND with tx_ready=0, then start again -> tx_valid drops the next cycle; no done; byte_cnt=1; the new start is accepted and the message completes. A start raised while busy is ignored.
- ROM_MSG_CRLF_EN defined, message 4F 4B 00 -> bytes 0x4F,0x4B,0x0D,0x0A; byte_cnt=4; done after the 0x0A handshake. Applying rst_n=0 mid-message -> all outputs return to their reset values the next cycle.
